// File: rtl/i2c_slave_regfile.sv
// I2C target with a local register file. SCL/SDA are oversampled on clk;
// frames are {slave addr, R/W, register addr, data...}.
// Optional build macro: I2C_SLV_AUTOINC_EN enables register pointer
// auto-increment, which allows multi-byte writes and continued reads.
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR  = 7'h50,
    parameter int         REG_DEPTH = 16,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       reg_wr,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy
);

`ifdef I2C_SLV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int         PW       = $clog2(REG_DEPTH);
    localparam logic [8:0] DEPTH9   = 9'(REG_DEPTH);
    localparam logic [7:0] LAST_PTR = 8'(REG_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_REG, S_ACK_R,
        S_WDATA, S_ACK_W, S_RDATA, S_RACK, S_WAIT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_scl_h;
    logic       r_sda_s1, r_sda_s2, r_sda_h;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_mack;
    logic       r_phase;   // 0: before the ACK-slot falling edge, 1: inside the ACK slot
    logic [7:0] r_regs [REG_DEPTH];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_bit, w_last;
    logic [7:0] w_byte, w_rd_data, w_ptr_inc;
    logic       w_addr_ok, w_reg_ok;
    logic       w_cnt_en, w_shift_en, w_addr_done, w_ptr_load, w_commit;
    logic       w_ack_drive, w_release, w_rd_load, w_rd_shift, w_mack_smp, w_phase_set;

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
    assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
    assign w_bit      = r_sda_s2;
    assign w_last     = (r_cnt == 3'd7);
    assign w_byte     = {r_shift[6:0], w_bit};
    assign w_addr_ok  = (w_byte[7:1] == SLV_ADDR);
    assign w_reg_ok   = ({1'b0, w_byte} < DEPTH9);
    assign w_rd_data  = r_regs[r_ptr[PW-1:0]];
    assign w_ptr_inc  = (r_ptr == LAST_PTR) ? 8'd0 : r_ptr + 8'd1;

    // Two-stage synchronizers plus one history stage for edge detection; idle bus is high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_h} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode; START/STOP override every state
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:  if (w_scl_rise && w_last) w_state_nxt = w_addr_ok ? S_ACK_A : S_WAIT;
                S_ACK_A: if (w_scl_fall && r_phase) w_state_nxt = r_rw ? S_RDATA : S_REG;
                S_REG:   if (w_scl_rise && w_last) w_state_nxt = w_reg_ok ? S_ACK_R : S_WAIT;
                S_ACK_R: if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
                S_WDATA: if (w_scl_rise && w_last) w_state_nxt = S_ACK_W;
                S_ACK_W: if (w_scl_fall && r_phase) w_state_nxt = AUTOINC ? S_WDATA : S_WAIT;
                S_RDATA: if (w_scl_rise && w_last) w_state_nxt = S_RACK;
                S_RACK:  if (w_scl_fall && r_phase)
                             w_state_nxt = (AUTOINC && !r_mack) ? S_RDATA : S_WAIT;
                default: ;
            endcase
        end
    end

    // Per-state datapath strobes; SDA is only ever changed on an SCL falling edge
    always_comb begin
        w_cnt_en    = 1'b0;
        w_shift_en  = 1'b0;
        w_addr_done = 1'b0;
        w_ptr_load  = 1'b0;
        w_commit    = 1'b0;
        w_ack_drive = 1'b0;
        w_release   = 1'b0;
        w_rd_load   = 1'b0;
        w_rd_shift  = 1'b0;
        w_mack_smp  = 1'b0;
        w_phase_set = 1'b0;
        case (r_state)
            S_ADDR: begin
                w_cnt_en    = w_scl_rise;
                w_shift_en  = w_scl_rise;
                w_addr_done = w_scl_rise && w_last && w_addr_ok;
            end
            S_REG: begin
                w_cnt_en   = w_scl_rise;
                w_shift_en = w_scl_rise;
                w_ptr_load = w_scl_rise && w_last && w_reg_ok;
            end
            S_WDATA: begin
                w_cnt_en   = w_scl_rise;
                w_shift_en = w_scl_rise;
                w_commit   = w_scl_rise && w_last;
            end
            S_ACK_A, S_ACK_R, S_ACK_W: begin
                w_ack_drive = w_scl_fall && !r_phase;
                w_phase_set = w_scl_fall && !r_phase;
                w_rd_load   = w_scl_fall && r_phase && (r_state == S_ACK_A) && r_rw;
                w_release   = w_scl_fall && r_phase && !w_rd_load;
            end
            S_RDATA: begin
                w_cnt_en   = w_scl_rise;
                w_rd_shift = w_scl_fall;
            end
            S_RACK: begin
                w_release   = w_scl_fall && !r_phase;
                w_phase_set = w_scl_fall && !r_phase;
                w_mack_smp  = w_scl_rise && r_phase;
                w_rd_load   = w_scl_fall && r_phase && AUTOINC && !r_mack;
            end
            default: ;
        endcase
    end

    // Shift/count/pointer datapath, register file, SDA drive and status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sda_o       <= 1'b1;
            reg_wr      <= 1'b0;
            reg_wr_addr <= 8'h00;
            reg_wr_data <= 8'h00;
            busy        <= 1'b0;
            r_cnt       <= 3'd0;
            r_shift     <= 8'h00;
            r_ptr       <= 8'h00;
            r_rw        <= 1'b0;
            r_mack      <= 1'b1;
            r_phase     <= 1'b0;
            r_regs      <= '{default: RST_VAL};
        end else begin
            reg_wr  <= 1'b0;
            r_phase <= (w_state_nxt != r_state) ? 1'b0 : (r_phase | w_phase_set);
            if (w_start || w_stop) begin
                sda_o <= 1'b1;
                busy  <= 1'b0;
                r_cnt <= 3'd0;
            end else begin
                if (w_cnt_en)   r_cnt   <= r_cnt + 3'd1;
                if (w_shift_en) r_shift <= w_byte;
                if (w_addr_done) begin
                    busy <= 1'b1;
                    r_rw <= w_bit;
                end
                // An out-of-range register byte is NACKed and leaves the pointer untouched
                if (w_ptr_load) r_ptr <= w_byte;
                if (w_commit) begin
                    r_regs[r_ptr[PW-1:0]] <= w_byte;
                    reg_wr      <= 1'b1;
                    reg_wr_addr <= r_ptr;
                    reg_wr_data <= w_byte;
                    if (AUTOINC) r_ptr <= w_ptr_inc;
                end
                if (w_ack_drive) sda_o <= 1'b0;
                if (w_release)   sda_o <= 1'b1;
                // MSB goes straight to the pin; the remaining bits queue up behind it
                if (w_rd_load) begin
                    r_shift <= {w_rd_data[6:0], 1'b1};
                    sda_o   <= w_rd_data[7];
                    if (AUTOINC) r_ptr <= w_ptr_inc;
                end
                if (w_rd_shift) begin
                    sda_o   <= r_shift[7];
                    r_shift <= {r_shift[6:0], 1'b1};
                end
                if (w_mack_smp) r_mack <= w_bit;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, behavioural register
// model and a queue of expected write strobes. Follows I2C_SLV_AUTOINC_EN.
module tb_i2c_slave_regfile;

`ifdef I2C_SLV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam logic [6:0] SLV   = 7'h50;
    localparam int         DEPTH = 16;
    localparam int         Q     = 50;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       scl    = 1'b1;
    logic       m_sda  = 1'b1;
    logic       sda_o, reg_wr, busy;
    logic [7:0] reg_wr_addr, reg_wr_data;
    wire        sda_bus;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_regs [DEPTH];
    logic [3:0]  m_ptr;
    logic        sda_hi_all;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    assign sda_bus = m_sda & sda_o;

    i2c_slave_regfile #(.SLV_ADDR(SLV), .REG_DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
        .clk(clk), .resetn(resetn), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reg_wr) obs_q.push_back({reg_wr_addr, reg_wr_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q; scl = 1'b1; #Q;
            sda_hi_all = sda_hi_all & sda_o; #Q; scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q; scl = 1'b1; #Q;
        ack = ~sda_bus;
        sda_hi_all = sda_hi_all & sda_o; #Q; scl = 1'b0; #Q;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d, output logic rel);
        m_sda = 1'b1;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #Q; scl = 1'b1; #Q; d = {d[6:0], sda_bus}; #Q; scl = 1'b0; #Q;
        end
        m_sda = ~mack; #Q; scl = 1'b1; #Q; rel = sda_o; #Q; scl = 1'b0; #Q;
        m_sda = 1'b1;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, ":wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, ":wr_pulse"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wr_txn(input string tag, input logic [6:0] a, input logic [7:0] r,
                          input int n, input logic [7:0] d0, input logic [7:0] d1);
        logic       ack, live;
        logic [7:0] d;
        sda_hi_all = 1'b1;
        bus_start();
        send_byte({a, 1'b0}, ack);
        live = (a == SLV);
        check({tag, ":addr_ack"}, 32'(ack), 32'(live));
        check({tag, ":busy"}, 32'(busy), 32'(live));
        send_byte(r, ack);
        live = live && (int'(r) < DEPTH);
        check({tag, ":reg_ack"}, 32'(ack), 32'(live));
        if (live) m_ptr = r[3:0];
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : d1;
            send_byte(d, ack);
            live = live && (k == 0 || AUTOINC);
            check({tag, ":data_ack"}, 32'(ack), 32'(live));
            if (live) begin
                m_regs[m_ptr] = d;
                exp_q.push_back({4'h0, m_ptr, d});
                if (AUTOINC) m_ptr = m_ptr + 4'd1;
            end
        end
        bus_stop();
        check({tag, ":busy_after_stop"}, 32'(busy), 32'd0);
        if (a != SLV) check({tag, ":sda_released"}, 32'(sda_hi_all), 32'd1);
        compare_writes(tag);
    endtask

    task automatic rd_txn(input string tag, input logic setreg, input logic [7:0] r, input int n);
        logic       ack, rel;
        logic [7:0] d, e;
        if (setreg) begin
            bus_start();
            send_byte({SLV, 1'b0}, ack);
            check({tag, ":addrw_ack"}, 32'(ack), 32'd1);
            send_byte(r, ack);
            check({tag, ":reg_ack"}, 32'(ack), 32'd1);
            m_ptr = r[3:0];
        end
        bus_start();
        send_byte({SLV, 1'b1}, ack);
        check({tag, ":addrr_ack"}, 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d, rel);
            if (k == 0 || AUTOINC) begin
                e = m_regs[m_ptr];
                if (AUTOINC) m_ptr = m_ptr + 4'd1;
            end else begin
                e = 8'hFF;
            end
            check({tag, ":data"}, 32'(d), 32'(e));
            if (k == n - 1) check({tag, ":sda_rel"}, 32'(rel), 32'd1);
        end
        bus_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb, r, d;
        int         n;

        model_reset();
        resetn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst:sda_o", 32'(sda_o), 32'd1);
        check("rst:reg_wr", 32'(reg_wr), 32'd0);
        check("rst:wr_addr", 32'(reg_wr_addr), 32'd0);
        check("rst:wr_data", 32'(reg_wr_data), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        #100;

        wr_txn("w_a5", SLV, 8'h03, 1, 8'hA5, 8'h00);
        rd_txn("r_a5", 1'b1, 8'h03, 1);
        rd_txn("r_ptr_keep", 1'b0, 8'h00, 1);
        wr_txn("w_badaddr", 7'h51, 8'h03, 1, 8'h77, 8'h00);
        wr_txn("w_badreg", SLV, 8'h20, 1, 8'h99, 8'h00);
        wr_txn("w_wrap", SLV, 8'h0F, 2, 8'h11, 8'h22);
        rd_txn("r_f", 1'b1, 8'h0F, 1);
        rd_txn("r_0", 1'b1, 8'h00, 1);
        rd_txn("r_mack", 1'b1, 8'h0F, 2);

        for (int it = 0; it < 8; it++) begin
            r = 8'($urandom_range(0, 19));
            d = 8'($urandom);
            n = int'($urandom_range(1, 2));
            wr_txn("rnd_wr", SLV, r, n, d, 8'($urandom));
            rd_txn("rnd_rd", 1'b1, 8'($urandom_range(0, 15)), 1);
        end

        // Reset asserted while the target holds SDA low in a data-byte ACK
        rb = 8'h3C;
        bus_start();
        send_byte({SLV, 1'b0}, ack);
        send_byte(8'h05, ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = rb[i]; #Q; scl = 1'b1; #(2 * Q); scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q; scl = 1'b1; #Q;
        check("mid_rst:ack_low", 32'(sda_o), 32'd0);
        resetn = 1'b0;
        #1;
        check("mid_rst:sda_async", 32'(sda_o), 32'd1);
        check("mid_rst:busy", 32'(busy), 32'd0);
        check("mid_rst:wr_addr", 32'(reg_wr_addr), 32'd0);
        check("mid_rst:wr_data", 32'(reg_wr_data), 32'd0);
        #(Q - 1); scl = 1'b0; #Q;
        #20;
        resetn = 1'b1;
        #20;
        model_reset();
        obs_q.delete();
        exp_q.delete();
        bus_stop();
        rd_txn("post_rst_ptr", 1'b0, 8'h00, 1);
        rd_txn("post_rst_r5", 1'b1, 8'h05, 1);
        rd_txn("post_rst_r3", 1'b1, 8'h03, 1);
        wr_txn("post_rst_wr", SLV, 8'h07, 1, 8'h5A, 8'h00);
        rd_txn("post_rst_rd", 1'b1, 8'h07, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
